// File: rtl/mcp320x_scan_spi.sv
// Channel-scanning SPI master for the MCP3204/MCP3208 ADCs. Each conversion is
// emitted as a one-cycle tagged word; frames come from an internal timer or start.
//
// state | meaning
// IDLE  | waiting for a frame trigger, cs high
// TCSH  | cs-high recovery time before a conversion
// XFER  | 19 SCK periods with cs low: command out, result in
// DONE  | result word presented for one cycle, next channel or back to IDLE
module mcp320x_scan_spi #(
  parameter int unsigned FCLK      = 100_000_000,
  parameter int unsigned FSMPL     = 500,
  parameter int          NUM_CH    = 4,
  parameter bit          SGL       = 1'b1,
  parameter int          SCK_DIV   = 100,
  parameter int          TCSH_CLKS = 50,
  parameter bit          FREE_RUN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        ovr_clr,
  input  logic        miso,
  output logic        mosi,
  output logic        sck,
  output logic        cs,
  output logic [11:0] data,
  output logic [2:0]  ch,
  output logic        dv,
  output logic        last,
  output logic        busy,
  output logic        ovr
);

  localparam int unsigned FRAME_CLKS = FCLK / FSMPL;
  localparam int unsigned CONV_CLKS  = TCSH_CLKS + 19 * SCK_DIV + 1;
  localparam int FW = (FRAME_CLKS > 1) ? $clog2(FRAME_CLKS) : 1;
  localparam int DW = $clog2(SCK_DIV);
  localparam int TW = (TCSH_CLKS > 1) ? $clog2(TCSH_CLKS) : 1;

  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CLKS - 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(SCK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF   = DW'(SCK_DIV / 2);
  localparam logic [DW-1:0] DIV_PRE    = DW'(SCK_DIV / 2 - 1);
  localparam logic [TW-1:0] TCSH_LOAD  = TW'(TCSH_CLKS - 1);
  localparam logic [2:0]    LAST_CH    = 3'(NUM_CH - 1);

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("mcp320x_scan_spi: NUM_CH must be 1..8");
  end
  if ((SCK_DIV % 2) != 0 || SCK_DIV < 4) begin : g_bad_sck_div
    $error("mcp320x_scan_spi: SCK_DIV must be even and >= 4");
  end
  if (TCSH_CLKS < 1) begin : g_bad_tcsh
    $error("mcp320x_scan_spi: TCSH_CLKS must be >= 1");
  end
  if (FREE_RUN && (FRAME_CLKS < NUM_CH * CONV_CLKS + 1)) begin : g_bad_rate
    $error("mcp320x_scan_spi: frame period too short for NUM_CH conversions");
  end

  typedef enum logic [1:0] {IDLE, TCSH, XFER, DONE} state_t;

  state_t        state, state_nx;
  logic [FW-1:0] frame_cnt;
  logic [TW-1:0] tcsh_cnt, tcsh_nx;
  logic [DW-1:0] div_cnt, div_nx;
  logic [4:0]    bit_cnt, bit_nx;
  logic [2:0]    ch_idx, ch_nx;
  logic [11:0]   shift;
  logic          trig, trig_q;
  logic          end_of_word, capture;
  logic          cs_nx, sck_nx, mosi_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      frame_cnt <= '0;
    else if (FREE_RUN)
      frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + 1'b1;
  end

  // Trigger is registered once, so a frame always starts one clock after it is seen.
  assign trig = FREE_RUN ? (frame_cnt == FRAME_LAST) : start;
  assign busy = (state != IDLE);

  always_comb begin
    state_nx = state;
    tcsh_nx  = tcsh_cnt;
    div_nx   = div_cnt;
    bit_nx   = bit_cnt;
    ch_nx    = ch_idx;
    case (state)
      IDLE: begin
        if (trig_q) begin
          state_nx = TCSH;
          tcsh_nx  = TCSH_LOAD;
          ch_nx    = 3'd0;
        end
      end
      TCSH: begin
        if (tcsh_cnt == '0) begin
          state_nx = XFER;
          div_nx   = '0;
          bit_nx   = 5'd0;
        end else begin
          tcsh_nx = tcsh_cnt - 1'b1;
        end
      end
      XFER: begin
        if (div_cnt == DIV_LAST) begin
          div_nx = '0;
          if (bit_cnt == 5'd18) state_nx = DONE;
          else                  bit_nx   = bit_cnt + 5'd1;
        end else begin
          div_nx = div_cnt + 1'b1;
        end
      end
      DONE: begin
        if (ch_idx == LAST_CH) begin
          state_nx = IDLE;
        end else begin
          state_nx = TCSH;
          tcsh_nx  = TCSH_LOAD;
          ch_nx    = ch_idx + 3'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Pins are registered from next-state values so they are glitch-free and
  // still line up cycle-exactly with the state they belong to.
  always_comb begin
    cs_nx   = (state_nx != XFER);
    sck_nx  = (state_nx == XFER) && (div_nx >= DIV_HALF);
    mosi_nx = 1'b0;
    if (state_nx == XFER) begin
      case (bit_nx)
        5'd0:    mosi_nx = 1'b1;
        5'd1:    mosi_nx = SGL;
        5'd2:    mosi_nx = ch_nx[2];
        5'd3:    mosi_nx = ch_nx[1];
        5'd4:    mosi_nx = ch_nx[0];
        default: mosi_nx = 1'b0;
      endcase
    end
  end

  assign end_of_word = (state == XFER) && (div_cnt == DIV_LAST) && (bit_cnt == 5'd18);
  assign capture     = (state == XFER) && (div_cnt == DIV_PRE) && (bit_cnt >= 5'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tcsh_cnt <= '0;
      div_cnt  <= '0;
      bit_cnt  <= 5'd0;
      ch_idx   <= 3'd0;
      shift    <= 12'd0;
      trig_q   <= 1'b0;
      cs       <= 1'b1;
      sck      <= 1'b0;
      mosi     <= 1'b0;
      data     <= 12'd0;
      ch       <= 3'd0;
      dv       <= 1'b0;
      last     <= 1'b0;
      ovr      <= 1'b0;
    end else begin
      state    <= state_nx;
      tcsh_cnt <= tcsh_nx;
      div_cnt  <= div_nx;
      bit_cnt  <= bit_nx;
      ch_idx   <= ch_nx;
      trig_q   <= trig;
      cs       <= cs_nx;
      sck      <= sck_nx;
      mosi     <= mosi_nx;
      if (capture) shift <= {shift[10:0], miso};
      dv   <= end_of_word;
      last <= end_of_word && (ch_idx == LAST_CH);
      if (end_of_word) begin
        data <= shift;
        ch   <= ch_idx;
      end
      if (trig_q && busy) ovr <= 1'b1;
      else if (ovr_clr)   ovr <= 1'b0;
    end
  end

endmodule

// File: doc/mcp320x_scan_spi.md
# mcp320x_scan_spi

Parametrised SPI master for the MCP3204/MCP3208 12-bit ADC family that scans channels 0..NUM_CH-1 per frame. Frames are started by an internal sample-rate timer (free-running) or by an external `start` pulse (triggered). Each conversion is emitted as a one-cycle tagged word (data, channel, last-of-frame). It sits between the ADC pins and the multi-lead ECG filter chain, replacing the single-channel fixed-rate front end.

## Interface
- FCLK, 100e6: input clock frequency in Hz.
- FSMPL, 500: frame rate in Hz, used in free-running mode only.
- NUM_CH, 4: channels scanned per frame, 1..8.
- SGL, 1: 1 = single-ended, 0 = differential (pair code = channel index).
- SCK_DIV, 100: clk cycles per SCK period; even, >= 4.
- TCSH_CLKS, 50: minimum CS-high clocks before every conversion; >= 1.
- FREE_RUN, 1: 1 = internal frame timer, 0 = `start` input.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  frame trigger pulse; ignored when FREE_RUN=1.
- ovr_clr  in  1  clears `ovr`.
- miso  in  1  ADC Dout.
- mosi  out  1  ADC Din.
- sck  out  1  SPI clock, CPOL=0.
- cs  out  1  active-low chip select.
- data  out  12  conversion result.
- ch  out  3  channel of `data`.
- dv  out  1  one-cycle data-valid pulse.
- last  out  1  high with `dv` on channel NUM_CH-1.
- busy  out  1  frame in progress.
- ovr  out  1  sticky overrun flag.

## Operation
- Reset values: cs=1, sck=0, mosi=0, data=0, ch=0, dv=0, last=0, busy=0, ovr=0. Internal state = IDLE, all counters = 0.
- Frame trigger:
  - FREE_RUN=1: frame timer counts 0..FCLK/FSMPL-1 and wraps; the tick fires on count FCLK/FSMPL-1. The timer runs from reset regardless of state.
  - FREE_RUN=0: trigger is `start`=1 sampled on a clk edge.
- States:
  - IDLE: cs=1, busy=0. A trigger moves to TCSH with channel index = 0.
  - TCSH: cs=1, busy=1, held for TCSH_CLKS cycles, then XFER.
  - XFER: cs=0, busy=1, 19 SCK periods long.
  - DONE: one cycle; cs=1, dv=1, data/ch/last updated. If channel index < NUM_CH-1, increment it and go to TCSH; otherwise go to IDLE.
- XFER bit slots, index b = 0..18. Each slot is SCK_DIV clocks with divider d = 0..SCK_DIV-1.
  - sck = 1 when d >= SCK_DIV/2, else 0.
  - mosi updates at d=0 (SCK low):
    - b0 = 1 (start bit)
    - b1 = SGL
    - b2..b4 = channel index bits [2:0], MSB first
    - b5..b18 = 0
  - b5 is the sample period. b6 is the null bit (ignored).
  - b7..b18 carry B11..B0. miso is captured into a shift register on the clk edge where d = SCK_DIV/2, i.e. the SCK rising edge.
- Overrun: a trigger arriving while busy=1 is dropped and sets ovr=1. ovr stays set until `ovr_clr`. If set and clear happen in the same cycle, set wins.
- A frame that is dropped does not disturb the frame in progress.
- Elaboration check (FREE_RUN=1): FCLK/FSMPL must be >= NUM_CH*(TCSH_CLKS+19*SCK_DIV+1)+1, otherwise $error. NUM_CH outside 1..8, or an odd SCK_DIV, is also an $error.

## Timing
- Trigger accepted at edge T: busy=1 and TCSH is entered from T+1. cs falls at T+1+TCSH_CLKS.
- cs stays low for exactly 19*SCK_DIV clocks. The first sck rise is SCK_DIV/2 clocks after cs falls.
- dv rises on the first cycle cs is high again.
- Per-channel period = TCSH_CLKS + 19*SCK_DIV + 1 clocks. Consecutive dv pulses are exactly this far apart.
- busy falls on the cycle after the last dv.
- data/ch/last hold their values until the next dv. last is 0 outside dv.
- mosi is 0 whenever cs=1. sck is 0 whenever not in XFER.
- rst_n low mid-XFER: all outputs return to reset values immediately (asynchronous). After release, no partial word is emitted, and the next trigger starts with TCSH and channel index 0.

## Test plan
- Single frame: FREE_RUN=0, NUM_CH=4, SCK_DIV=8, TCSH_CLKS=4, ADC model returning 0xA50+ch, one `start` pulse.
  - Required: 4 dv pulses with data 0xA50..0xA53, ch 0..3, last only on ch 3.
  - dv spacing 157 clocks; first cs fall 5 clocks after start; busy low afterwards.
- MOSI command check: SGL=1 then SGL=0, NUM_CH=8.
  - Required: the model decodes start=1, SGL, and D2..D0 = channel for all 8 channels.
  - In both modes, mosi=0 outside b0..b4 and while cs=1.
- Free-running: FCLK=1e6, FSMPL=1000, SCK_DIV=8, TCSH_CLKS=4, NUM_CH=2.
  - Required: frames every 1000 clocks, 2 dv pulses per frame, ovr stays 0 over 5 frames.
- Overrun: FREE_RUN=0, second `start` 100 clocks after the first.
  - Required: ovr=1, the frame still yields NUM_CH words, and the extra frame is not run.
  - ovr_clr and start together on a busy frame: ovr stays 1.
- Reset mid-XFER: assert rst_n at bit 10 of channel 1.
  - Required: cs=1, sck=0, dv=0 in the same cycle.
  - After release and a new start, first dv has ch=0 with correct data.
- Extreme data: model returns 0xFFF, then 0x000, then 0x800.
  - Required: exact values out, confirming the null bit is skipped and the MSB is aligned.
